// File: rtl/sirv_gnrl_fifo.sv
// General synchronous FIFO: registered full/empty flags, combinational head read,
// arbitrary depth with wrap-at-DP pointers and an explicit occupancy counter.
module sirv_gnrl_fifo #(
  parameter int DW = 32,
  parameter int DP = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_vld,
  output logic                     i_rdy,
  input  logic [DW-1:0]            i_dat,
  output logic                     o_vld,
  input  logic                     o_rdy,
  output logic [DW-1:0]            o_dat,
  output logic [$clog2(DP+1)-1:0]  count
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);
  localparam logic [PW-1:0] LAST = PW'(DP - 1);
  localparam logic [CW-1:0] FULL = CW'(DP);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          push;
  logic          pop;
  logic [DW-1:0] mem [DP];

  // Flags come only from the counter, so neither side sees the other's handshake.
  assign i_rdy = (cnt != FULL);
  assign o_vld = (cnt != '0);
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;
  assign count = cnt;
  assign o_dat = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
    end else if (push) begin
      wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr <= '0;
    end else if (pop) begin
      rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + 1'b1;
    end else if (pop && !push) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Storage is deliberately unreset; only the written entry is enabled.
  for (genvar k = 0; k < DP; k++) begin : g_mem
    always_ff @(posedge clk) begin
      if (push && (wptr == PW'(k))) begin
        mem[k] <= i_dat;
      end
    end
  end

endmodule

// File: tb/tb_sirv_gnrl_fifo.sv
// Bench for sirv_gnrl_fifo: directed scenarios on DP=4 plus random runs on
// DP=1/3/4, all checked by per-instance queue scoreboards.
module tb_sirv_gnrl_fifo;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [2:0] vld;
  logic [2:0] rdy;
  logic [2:0][7:0] din;
  logic [2:0] irdy;
  logic [2:0] ovld;
  logic [2:0][7:0] dout;
  logic [2:0][2:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int D = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    localparam int CW = $clog2(D + 1);
    logic [CW-1:0] cw;
    logic [7:0] od;
    logic ir;
    logic ov;
    logic [7:0] sb[$];
    int n;

    sirv_gnrl_fifo #(.DW(8), .DP(D)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .i_vld (vld[g]),
      .i_rdy (ir),
      .i_dat (din[g]),
      .o_vld (ov),
      .o_rdy (rdy[g]),
      .o_dat (od),
      .count (cw)
    );

    assign irdy[g] = ir;
    assign ovld[g] = ov;
    assign dout[g] = od;
    assign cnt[g]  = 3'(cw);

    always @(negedge rst_n) sb.delete();

    // Reference: a plain queue of capacity D, advanced by the upcoming edge.
    always @(negedge clk) begin
      if (rst_n) begin
        n = sb.size();
        chk($sformatf("dp%0d_count", D), int'(cw), n);
        chk($sformatf("dp%0d_i_rdy", D), int'(ir), int'(n != D));
        chk($sformatf("dp%0d_o_vld", D), int'(ov), int'(n != 0));
        if (n != 0) chk($sformatf("dp%0d_o_dat", D), int'(od), int'(sb[0]));
        if (n != 0 && rdy[g]) void'(sb.pop_front());
        if (n != D && vld[g]) sb.push_back(din[g]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int lim;
  int pv;
  int pr;

  initial begin
    vld = '0;
    rdy = '0;
    din = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_async_o_vld", int'(ovld[2]), 0);
    chk("rst_async_i_rdy", int'(irdy[2]), 1);
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Scenario 1: idle after reset
    chk("s1_i_rdy", int'(irdy[2]), 1);
    chk("s1_o_vld", int'(ovld[2]), 0);
    chk("s1_count", int'(cnt[2]), 0);

    // Scenario 2: fill, then offer a fifth word
    for (int i = 1; i <= 5; i++) begin
      vld[2] = 1'b1;
      din[2] = 8'(i * 8'h11);
      step();
      chk("s2_head", int'(dout[2]), 8'h11);
    end
    chk("s2_count_full", int'(cnt[2]), 4);
    chk("s2_i_rdy_full", int'(irdy[2]), 0);
    vld[2] = 1'b0;

    // Scenario 3: drain
    rdy[2] = 1'b1;
    repeat (4) step();
    rdy[2] = 1'b0;
    chk("s3_o_vld", int'(ovld[2]), 0);
    chk("s3_count", int'(cnt[2]), 0);

    // Scenario 4: steady state at count 2 across wrap
    vld[2] = 1'b1;
    din[2] = 8'h60;
    step();
    din[2] = 8'h61;
    step();
    rdy[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      din[2] = 8'(8'h62 + i);
      step();
      chk("s4_count", int'(cnt[2]), 2);
    end
    vld[2] = 1'b0;
    lim = 0;
    while (ovld[2] && lim < 8) begin
      step();
      lim++;
    end
    chk("s4_drained", int'(ovld[2]), 0);
    rdy[2] = 1'b0;

    // Scenario 5: full with simultaneous push offer and pop
    vld[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din[2] = 8'(8'h70 + i);
      step();
    end
    din[2] = 8'h74;
    rdy[2] = 1'b1;
    step();
    chk("s5_pop_only", int'(cnt[2]), 3);
    rdy[2] = 1'b0;
    step();
    chk("s5_accept_next", int'(cnt[2]), 4);
    vld[2] = 1'b0;
    rdy[2] = 1'b1;
    repeat (4) step();
    rdy[2] = 1'b0;
    chk("s5_empty", int'(cnt[2]), 0);

    // Scenario 6: reset between edges discards queued words
    vld[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din[2] = 8'(8'h80 + i);
      step();
    end
    vld[2] = 1'b0;
    chk("s6_count_pre", int'(cnt[2]), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_o_vld", int'(ovld[2]), 0);
    chk("s6_count", int'(cnt[2]), 0);
    chk("s6_i_rdy", int'(irdy[2]), 1);
    step();
    rst_n = 1'b1;
    vld[2] = 1'b1;
    din[2] = 8'hA5;
    step();
    vld[2] = 1'b0;
    chk("s6_o_vld_new", int'(ovld[2]), 1);
    chk("s6_o_dat_new", int'(dout[2]), 8'hA5);
    chk("s6_count_new", int'(cnt[2]), 1);
    rdy[2] = 1'b1;
    step();
    rdy[2] = 1'b0;

    // Random phases with shifting fill/drain bias
    for (int c = 0; c < 3000; c++) begin
      case ((c / 250) % 4)
        0: begin pv = 80; pr = 20; end
        1: begin pv = 20; pr = 80; end
        2: begin pv = 50; pr = 50; end
        default: begin pv = 90; pr = 90; end
      endcase
      for (int g = 0; g < 3; g++) begin
        vld[g] = ($urandom_range(0, 99) < pv);
        rdy[g] = ($urandom_range(0, 99) < pr);
        din[g] = 8'($urandom);
      end
      step();
    end
    vld = '0;
    rdy = '1;
    repeat (6) step();
    chk("final_empty", int'(ovld), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
